fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
- Control and storage stage directly upstream of the MAC block in the microphone FIR path.
- Accepts one 24-bit PCM sample per handshake and writes it into a circular delay line.
- Drives the MAC inputs once per tap: a = sample, b = coefficient, c = running accumulator. Captures the MAC's 48-bit output back into the accumulator.
- After TAPS cycles, emits one scaled, saturated filter output through a valid/ready handshake.

Parameters:
- TAPS, 32: filter length. Power of two, ≥ 2.
- SAMPLE_W, 24: input sample width. Sign-extended to 25 bits for mac_a.
- OUT_W, 24: output sample width.
- OUT_SHIFT, 17: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1: sole clock.
- rst_n  in  1: asynchronous, active-low reset.
- s_data  in  SAMPLE_W: input sample, signed.
- s_valid  in  1: input valid.
- s_ready  out  1: input ready.
- coef_we  in  1: coefficient write strobe.
- coef_addr  in  log2(TAPS): coefficient index k.
- coef_wdata  in  18: signed coefficient.
- mac_a  out  25: to MAC a.
- mac_b  out  18: to MAC b.
- mac_c  out  48: to MAC c.
- mac_out  in  48: from MAC out. Combinational: mac_out = mac_a*mac_b + mac_c in the same cycle.
- m_data  out  OUT_W: filtered sample, signed.
- m_valid  out  1: output valid.
- m_ready  in  1: output ready.
- m_sat  out  1: qualifies m_data; 1 if saturation occurred for this sample.
- busy  out  1: high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, wr_ptr=0, k=0, acc=0.
  - Outputs: s_ready=0, m_valid=0, m_data=0, m_sat=0, busy=1, mac_a=mac_b=mac_c=0.
- CLEAR:
  - Writes 0 to delay[k] and coef[k], one entry per cycle, k=0..TAPS-1.
  - coef_we ignored.
  - At k=TAPS-1: k←0, go to IDLE. s_ready first high TAPS cycles after rst_n deasserts.
- IDLE:
  - s_ready=1, busy=0.
  - coef_we writes coef[coef_addr]←coef_wdata on the same edge.
  - On s_valid&&s_ready:
    - delay[wr_ptr]←s_data.
    - acc←0, k←0, go to ACCUM.
    - If coef_we is also high that cycle, the write is applied before ACCUM begins.
- ACCUM (TAPS cycles):
  - s_ready=0.
  - mac_a = sign-extended delay[(wr_ptr−k) mod TAPS] (wraps naturally at pointer width).
  - mac_b = coef[k]; mac_c = acc.
  - Each edge: acc←mac_out, k←k+1.
  - When k=TAPS-1: wr_ptr←wr_ptr+1 (wraps TAPS-1→0), go to OUTPUT.
  - coef_we ignored; no error indication.
  - mac_a/b/c are 0 outside ACCUM.
- OUTPUT:
  - Registered on entry: y = acc >>> OUT_SHIFT (arithmetic).
    - If y > 2^(OUT_W-1)-1: m_data = that max, m_sat=1.
    - If y < −2^(OUT_W-1): m_data = that min, m_sat=1.
    - Otherwise m_data = y[OUT_W-1:0], m_sat=0.
  - m_valid=1. m_data and m_sat are held stable while m_ready=0.
  - On m_ready: m_valid←0, go to IDLE.
  - m_data retains its last value after the handshake; only m_valid qualifies it.
- Latency: sample accepted at edge T → m_valid high after edge T+TAPS.
- Throughput: one sample per TAPS+2 cycles, with m_ready tied high.
- Arithmetic:
  - The accumulator is 48-bit and wraps modulo 2^48 (no internal saturation).
  - The design relies on |Σ| < 2^47: TAPS·2^23·2^17 fits.
- Reset mid-operation (any state): immediately returns to CLEAR, discards the partial acc and any pending output, drops m_valid.

Test Plan:
- Post-reset:
  - Stimulus: deassert rst_n, TAPS=32.
  - Required: s_ready=0 for exactly 32 cycles, then 1. A sample sent before any coef writes → m_data=0, m_sat=0.
- Impulse response:
  - Stimulus: TAPS=4, OUT_SHIFT=0, coef = {1,2,3,4}. Samples 1,0,0,0,0.
  - Required: m_data sequence 1,2,3,4,0. Each m_valid arrives 4 cycles after acceptance.
- Saturation:
  - Stimulus: TAPS=4, OUT_SHIFT=0, all coef=131071, four samples of 8388607.
  - Required: m_data=8388607 with m_sat=1.
  - Negative case: samples −8388608 → m_data=−8388608, m_sat=1.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles with s_valid=1.
  - Required: m_data stable, s_ready=0 throughout; exactly one output per input, none dropped or duplicated.
- Coefficient write gating:
  - Stimulus: coef_we to addr 0 with value 100 during ACCUM.
  - Required: coef[0] unchanged; the same write issued in IDLE takes effect on the next sample.
- Reset mid-ACCUM:
  - Stimulus: pull rst_n low at tap 2.
  - Required: m_valid=0 immediately and the CLEAR sequence repeats. The next impulse yields the pure coefficient sequence with no stale history.

Source files
------------

// File: rtl/fir_tap_sequencer_if.sv
// Bus bundle for fir_tap_sequencer: sample input, coefficient port, MAC
// operand/result lines and the filtered-sample output with its status.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface fir_tap_sequencer_if #(
    parameter int TAPS     = 32,
    parameter int SAMPLE_W = 24,
    parameter int OUT_W    = 24
);
    localparam int AW = $clog2(TAPS);

    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic                coef_we;
    logic [AW-1:0]       coef_addr;
    logic [17:0]         coef_wdata;
    logic [24:0]         mac_a;
    logic [17:0]         mac_b;
    logic [47:0]         mac_c;
    logic [47:0]         mac_out;
    logic [OUT_W-1:0]    m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_sat;
    logic                busy;

    modport slave (
        input  s_data, s_valid, coef_we, coef_addr, coef_wdata, mac_out, m_ready,
        output s_ready, mac_a, mac_b, mac_c, m_data, m_valid, m_sat, busy
    );

    modport master (
        output s_data, s_valid, coef_we, coef_addr, coef_wdata, mac_out, m_ready,
        input  s_ready, mac_a, mac_b, mac_c, m_data, m_valid, m_sat, busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: stores samples in a circular delay line, walks TAPS
// taps through an external combinational MAC, then emits one shifted and
// saturated result per accepted sample over a valid/ready handshake.
module fir_tap_sequencer #(
    parameter int TAPS      = 32,
    parameter int SAMPLE_W  = 24,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_tap_sequencer_if.slave   bus
);
    localparam int                     AW      = $clog2(TAPS);
    localparam logic [AW-1:0]          K_LAST  = AW'(TAPS - 1);
    localparam logic signed [47:0]     OUT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
    localparam logic signed [47:0]     OUT_MIN = -(48'sd1 <<< (OUT_W - 1));

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCUM  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                     r_state;
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_k;
    logic signed [47:0]         r_acc;
    logic                       r_s_ready;
    logic                       r_busy;
    logic                       r_m_valid;
    logic [OUT_W-1:0]           r_m_data;
    logic                       r_m_sat;

    // Storage is zeroed by the CLEAR walk rather than by reset.
    logic [SAMPLE_W-1:0]        r_delay [TAPS];
    logic signed [17:0]         r_coef  [TAPS];

    logic                       w_in_accum;
    logic                       w_accept;
    logic [AW-1:0]              w_rd_idx;
    logic signed [SAMPLE_W-1:0] w_tap;
    logic signed [47:0]         w_y;
    logic [OUT_W-1:0]           w_sat_data;
    logic                       w_sat;

    assign w_in_accum = (r_state == S_ACCUM);
    assign w_accept   = (r_state == S_IDLE) && bus.s_valid && r_s_ready;

    // Newest sample pairs with coef[0]; the subtraction wraps at pointer width.
    assign w_rd_idx = r_wr_ptr - r_k;
    assign w_tap    = r_delay[w_rd_idx];

    // MAC operands are forced to zero outside ACCUM.
    assign bus.mac_a = w_in_accum ? 25'(w_tap)    : '0;
    assign bus.mac_b = w_in_accum ? r_coef[r_k]   : '0;
    assign bus.mac_c = w_in_accum ? r_acc         : '0;

    // The final MAC result is scaled as it lands, so OUTPUT is registered on entry.
    assign w_y = $signed(bus.mac_out) >>> OUT_SHIFT;

    // Saturate the scaled accumulator into the output width.
    always_comb begin
        w_sat      = 1'b0;
        w_sat_data = w_y[OUT_W-1:0];
        if (w_y > OUT_MAX) begin
            w_sat      = 1'b1;
            w_sat_data = OUT_MAX[OUT_W-1:0];
        end else if (w_y < OUT_MIN) begin
            w_sat      = 1'b1;
            w_sat_data = OUT_MIN[OUT_W-1:0];
        end
    end

    // Delay-line and coefficient storage: cleared one entry per cycle in CLEAR,
    // written by the host and the sample port only while IDLE.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_delay[r_k] <= '0;
            r_coef[r_k]  <= '0;
        end
        if (r_state == S_IDLE) begin
            if (bus.coef_we)
                r_coef[bus.coef_addr] <= bus.coef_wdata;
            if (w_accept)
                r_delay[r_wr_ptr] <= bus.s_data;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_wr_ptr  <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_k == K_LAST) begin
                        r_k       <= '0;
                        r_state   <= S_IDLE;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc     <= '0;
                        r_k       <= '0;
                        r_state   <= S_ACCUM;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= $signed(bus.mac_out);
                    r_k   <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_state   <= S_OUTPUT;
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_sat_data;
                        r_m_sat   <= w_sat;
                    end
                end
                S_OUTPUT: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_IDLE;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.busy    = r_busy;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_sat   = r_m_sat;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: a default 32-tap instance for the
// post-reset behaviour and a 4-tap, unshifted instance for arithmetic,
// handshake, coefficient gating and mid-operation reset.
module tb_fir_tap_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fir_tap_sequencer_if                b32 ();
    fir_tap_sequencer_if #(.TAPS(4))    b4 ();

    fir_tap_sequencer u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    fir_tap_sequencer #(.TAPS(4), .OUT_SHIFT(0)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // Combinational MAC models: out = a*b + c, modulo 2^48.
    logic signed [47:0] p32, p4;
    assign p32 = 48'($signed(b32.mac_a)) * 48'($signed(b32.mac_b));
    assign p4  = 48'($signed(b4.mac_a))  * 48'($signed(b4.mac_b));
    assign b32.mac_out = p32 + b32.mac_c;
    assign b4.mac_out  = p4  + b4.mac_c;

    // Handshake counters on the 4-tap instance.
    int in_cnt = 0;
    int out_cnt = 0;
    always @(posedge clk) begin
        if (b4.s_valid && b4.s_ready) in_cnt <= in_cnt + 1;
        if (b4.m_valid && b4.m_ready) out_cnt <= out_cnt + 1;
    end

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_idle4();
        int w = 0;
        while (!b4.s_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (!b4.s_ready) check("idle_timeout", 48'(b4.s_ready), 48'd1);
    endtask

    task automatic wcoef4(input logic [1:0] addr, input logic [17:0] val);
        wait_idle4();
        b4.coef_we = 1'b1; b4.coef_addr = addr; b4.coef_wdata = val;
        @(posedge clk); #1;
        b4.coef_we = 1'b0;
    endtask

    // Send one sample, optionally pulse a coef write during ACCUM, return result.
    task automatic run4(input logic [23:0] smp, input bit pulse_we,
                        output logic [23:0] d, output logic sat, output int lat);
        wait_idle4();
        b4.s_data = smp; b4.s_valid = 1'b1;
        @(posedge clk); #1;
        b4.s_valid = 1'b0;
        if (pulse_we) begin
            b4.coef_we = 1'b1; b4.coef_addr = 2'd0; b4.coef_wdata = 18'd100;
        end
        lat = 0;
        do begin
            @(posedge clk); #1; b4.coef_we = 1'b0; lat++;
        end while (!b4.m_valid && lat < 100);
        d = b4.m_data; sat = b4.m_sat;
    endtask

    logic [23:0] d;
    logic        sat;
    int          lat;
    int          rdy32, rdy4, bad, base_in, base_out, w;
    logic [23:0] neg_exp [4];
    logic        neg_sat [4];

    initial begin
        b32.s_data = '0; b32.s_valid = 1'b0; b32.coef_we = 1'b0; b32.coef_addr = '0;
        b32.coef_wdata = '0; b32.m_ready = 1'b1;
        b4.s_data = '0; b4.s_valid = 1'b0; b4.coef_we = 1'b0; b4.coef_addr = '0;
        b4.coef_wdata = '0; b4.m_ready = 1'b1;
        neg_exp[0] = 24'h7FFFFF; neg_sat[0] = 1'b1;
        neg_exp[1] = 24'hFC0002; neg_sat[1] = 1'b0;
        neg_exp[2] = 24'h800000; neg_sat[2] = 1'b1;
        neg_exp[3] = 24'h800000; neg_sat[3] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 48'(b4.s_ready), 48'd0);
        check("rst_m_valid", 48'(b4.m_valid), 48'd0);
        check("rst_busy",    48'(b4.busy),    48'd1);
        check("rst_m_data",  48'(b4.m_data),  48'd0);
        check("rst_mac",     48'({b4.mac_a, b4.mac_b} | 43'(b4.mac_c)), 48'd0);

        // Post-reset CLEAR length on both instances.
        rst_n = 1'b1;
        rdy32 = 0; rdy4 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (b32.s_ready && rdy32 == 0) rdy32 = i;
            if (b4.s_ready && rdy4 == 0) rdy4 = i;
        end
        check("clear_len32", 48'(rdy32), 48'd32);
        check("clear_len4",  48'(rdy4),  48'd4);
        check("idle_busy",   48'(b4.busy), 48'd0);

        // 32-tap: sample with all coefficients cleared.
        b32.s_data = 24'd1000; b32.s_valid = 1'b1;
        @(posedge clk); #1;
        b32.s_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!b32.m_valid && lat < 100);
        check("t32_lat",  48'(lat), 48'd32);
        check("t32_data", 48'(b32.m_data), 48'd0);
        check("t32_sat",  48'(b32.m_sat), 48'd0);

        // Impulse response.
        for (int k = 0; k < 4; k++) wcoef4(2'(k), 18'(k + 1));
        for (int n = 0; n < 5; n++) begin
            run4((n == 0) ? 24'd1 : 24'd0, 1'b0, d, sat, lat);
            check($sformatf("imp_data%0d", n), 48'(d), (n < 4) ? 48'(n + 1) : 48'd0);
            check($sformatf("imp_lat%0d", n),  48'(lat), 48'd4);
            check($sformatf("imp_sat%0d", n),  48'(sat), 48'd0);
        end

        // Coefficient write during ACCUM is ignored; in IDLE it lands.
        run4(24'd1, 1'b1, d, sat, lat);
        check("gate_accum", 48'(d), 48'd1);
        wcoef4(2'd0, 18'd100);
        run4(24'd1, 1'b0, d, sat, lat);
        check("gate_idle", 48'(d), 48'd102);
        wcoef4(2'd0, 18'd1);
        for (int n = 0; n < 4; n++) run4(24'd0, 1'b0, d, sat, lat);

        // Backpressure with s_valid held high.
        wait_idle4();
        base_in = in_cnt; base_out = out_cnt;
        b4.m_ready = 1'b0;
        b4.s_data = 24'd5; b4.s_valid = 1'b1;
        @(posedge clk); #1;
        b4.s_data = 24'd7;
        w = 0;
        while (!b4.m_valid && w < 50) begin @(posedge clk); #1; w++; end
        check("bp_first", 48'(b4.m_data), 48'd5);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (b4.m_data !== 24'd5 || b4.s_ready !== 1'b0 || b4.m_valid !== 1'b1 || b4.busy !== 1'b1)
                bad++;
        end
        check("bp_hold", 48'(bad), 48'd0);
        b4.m_ready = 1'b1;
        w = 0;
        while (in_cnt - base_in < 2 && w < 50) begin @(posedge clk); #1; w++; end
        b4.s_valid = 1'b0;
        w = 0;
        while (!b4.m_valid && w < 50) begin @(posedge clk); #1; w++; end
        check("bp_second", 48'(b4.m_data), 48'd17);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_cnt",  48'(in_cnt - base_in),   48'd2);
        check("bp_out_cnt", 48'(out_cnt - base_out), 48'd2);

        // Saturation, positive then negative.
        for (int k = 0; k < 4; k++) wcoef4(2'(k), 18'd131071);
        for (int n = 0; n < 4; n++) begin
            run4(24'h7FFFFF, 1'b0, d, sat, lat);
            check($sformatf("satp_data%0d", n), 48'(d), 48'h7FFFFF);
            check($sformatf("satp_flag%0d", n), 48'(sat), 48'd1);
        end
        for (int n = 0; n < 4; n++) begin
            run4(24'h800000, 1'b0, d, sat, lat);
            check($sformatf("satn_data%0d", n), 48'(d), 48'(neg_exp[n]));
            check($sformatf("satn_flag%0d", n), 48'(sat), 48'(neg_sat[n]));
        end

        // Reset at tap 2 of ACCUM.
        wait_idle4();
        b4.s_data = 24'd3; b4.s_valid = 1'b1;
        @(posedge clk); #1;
        b4.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_m_valid", 48'(b4.m_valid), 48'd0);
        check("mid_busy",    48'(b4.busy),    48'd1);
        check("mid_mac_a",   48'(b4.mac_a),   48'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy4 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (b4.s_ready && rdy4 == 0) rdy4 = i;
        end
        check("mid_clear_len", 48'(rdy4), 48'd4);
        for (int k = 0; k < 4; k++) wcoef4(2'(k), 18'(k + 1));
        for (int n = 0; n < 4; n++) begin
            run4((n == 0) ? 24'd1 : 24'd0, 1'b0, d, sat, lat);
            check($sformatf("mid_imp%0d", n), 48'(d), 48'(n + 1));
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
